// File: rtl/move_scheduler_pkg.sv
// Shared configuration for the move scheduler: default widths, FSM state
// encodings and the packed move descriptor layout.
package move_scheduler_pkg;

  localparam int CFG_MOVE_BUFFER_BITS = 2;
  localparam int CFG_DIV_W            = 24;
  localparam int CFG_MOVE_W           = 64;
  localparam int CFG_DESC_W           = 3 * CFG_MOVE_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Descriptor layout as stored in the FIFO, MSB first.
  typedef struct packed {
    logic [CFG_MOVE_W-1:0] duration;
    logic [CFG_MOVE_W-1:0] increment;
    logic [CFG_MOVE_W-1:0] incinc;
    logic                  dir;
  } move_desc_t;

  // Packed descriptor width for a given field width.
  function automatic int desc_width(input int move_w);
    return 3 * move_w + 1;
  endfunction

endpackage

// File: rtl/move_scheduler_fifo.sv
// Synchronous descriptor FIFO with full/empty/count and a flush that empties
// it in one cycle. Push while full and pop while empty are ignored; flush
// overrides both.
module move_scheduler_fifo #(
  parameter int DW = 193,
  parameter int AW = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_pop_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int            DEPTH      = 1 << AW;
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Buffered move sequencer: queues move descriptors, hands them to the step
// datapath one at a time, and produces the prescaled DDA tick.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no active move; pops the queue head when enabled
//   S_LOAD | one-cycle load pulse; act_* valid; zero-length moves end here
//   S_RUN  | prescaler running; tick every max(div,1) enabled cycles
//
// The head is popped and latched into act_* on the edge entering S_LOAD, so
// act_* are already valid while load is high. On the final tick of a move the
// next descriptor is popped directly, giving a single LOAD bubble between
// back-to-back moves.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int MOVE_BUFFER_BITS = CFG_MOVE_BUFFER_BITS,
  parameter int DIV_W            = CFG_DIV_W,
  parameter int MOVE_W           = CFG_MOVE_W
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [DIV_W-1:0]        clock_divisor,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [MOVE_W-1:0]       push_duration,
  input  logic [MOVE_W-1:0]       push_increment,
  input  logic [MOVE_W-1:0]       push_incinc,
  input  logic                    push_dir,
  output logic                    load,
  output logic [MOVE_W-1:0]       act_increment,
  output logic [MOVE_W-1:0]       act_incinc,
  output logic                    act_dir,
  output logic                    tick,
  output logic                    first_tick,
  output logic                    busy,
  output logic [MOVE_BUFFER_BITS:0] queue_count,
  output logic                    underrun,
  output logic [31:0]             moves_done
);

  localparam int DESC_W = desc_width(MOVE_W);

  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_prescaler;
  logic [MOVE_W-1:0] r_remaining;
  logic [MOVE_W-1:0] r_act_increment;
  logic [MOVE_W-1:0] r_act_incinc;
  logic              r_act_dir;
  logic              r_first;
  logic              r_underrun;
  logic [31:0]       r_moves_done;

  logic [DESC_W-1:0] w_push_desc;
  logic [DESC_W-1:0] w_head;
  logic [MOVE_W-1:0] w_head_duration;
  logic [MOVE_W-1:0] w_head_increment;
  logic [MOVE_W-1:0] w_head_incinc;
  logic              w_head_dir;
  logic              w_full;
  logic              w_empty;
  logic [DIV_W-1:0]  w_div_m1;
  logic              w_fire;
  logic              w_last;
  logic              w_idle_pop;
  logic              w_run_pop;
  logic              w_pop;
  logic              w_move_done;

  assign w_push_desc = {push_duration, push_increment, push_incinc, push_dir};

  move_scheduler_fifo #(
    .DW (DESC_W),
    .AW (MOVE_BUFFER_BITS)
  ) u_fifo (
    .i_clk       (CLK),
    .i_reset     (reset),
    .i_flush     (flush),
    .i_push      (push_valid),
    .i_push_data (w_push_desc),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (queue_count)
  );

  assign w_head_duration  = w_head[DESC_W-1 -: MOVE_W];
  assign w_head_increment = w_head[2*MOVE_W -: MOVE_W];
  assign w_head_incinc    = w_head[MOVE_W -: MOVE_W];
  assign w_head_dir       = w_head[0];

  // A divisor of 0 behaves as 1. The >= compare means a divisor shrunk below
  // the current prescaler count fires once immediately instead of wrapping.
  assign w_div_m1 = (r_div == '0) ? '0 : (r_div - DIV_W'(1));

  assign w_fire      = (r_state == S_RUN) && enable && !flush && (r_prescaler >= w_div_m1);
  assign w_last      = w_fire && (r_remaining <= MOVE_W'(1));
  assign w_idle_pop  = (r_state == S_IDLE) && enable && !flush && !w_empty;
  assign w_run_pop   = w_last && !w_empty;
  assign w_pop       = w_idle_pop || w_run_pop;
  assign w_move_done = w_last || ((r_state == S_LOAD) && (r_remaining == '0));

  assign push_ready    = !w_full && !flush;
  assign load          = (r_state == S_LOAD);
  assign busy          = (r_state != S_IDLE);
  assign tick          = w_fire;
  assign first_tick    = w_fire && r_first;
  assign act_increment = r_act_increment;
  assign act_incinc    = r_act_incinc;
  assign act_dir       = r_act_dir;
  assign underrun      = r_underrun;
  assign moves_done    = r_moves_done;

  // Divisor is sampled every cycle; the prescaler compares against this copy.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_div <= '0;
    end else begin
      r_div <= clock_divisor;
    end
  end

  // Sequencer FSM, prescaler, move countdown and status counters.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_prescaler     <= '0;
      r_remaining     <= '0;
      r_act_increment <= '0;
      r_act_incinc    <= '0;
      r_act_dir       <= 1'b0;
      r_first         <= 1'b0;
      r_underrun      <= 1'b0;
      r_moves_done    <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_prescaler <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_move_done) begin
        r_moves_done <= r_moves_done + 32'd1;
      end
      if (w_last && w_empty) begin
        r_underrun <= 1'b1;
      end
      if (w_pop) begin
        r_act_increment <= w_head_increment;
        r_act_incinc    <= w_head_incinc;
        r_act_dir       <= w_head_dir;
        r_remaining     <= w_head_duration;
        r_prescaler     <= '0;
        r_first         <= 1'b1;
        r_state         <= S_LOAD;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_LOAD: begin
            r_state <= (r_remaining == '0) ? S_IDLE : S_RUN;
          end
          S_RUN: begin
            if (w_fire) begin
              r_prescaler <= '0;
              r_remaining <= r_remaining - MOVE_W'(1);
              r_first     <= 1'b0;
              if (w_last) begin
                r_state <= S_IDLE;
              end
            end else if (enable) begin
              r_prescaler <= r_prescaler + DIV_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Buffered sequencer for coordinated moves, sitting between the SPI message decoder and the step-generation datapath (substep accumulator / DualHBridge).
- Accepts move descriptors (duration, increment, increment-increment, direction) into a FIFO and hands them to the datapath one at a time.
- Generates the prescaled DDA tick from clock_divisor and counts each move down to completion, so moves stream back-to-back without host latching.

Parameters:
- MOVE_BUFFER_BITS, 2, log2 of queue depth (depth 4)
- DIV_W, 24, clock divisor width
- MOVE_W, 64, width of duration/increment/incinc fields

Ports:
- CLK  in  1  system clock (16 MHz)
- reset  in  1  synchronous, active-high reset
- clock_divisor  in  DIV_W  CLK cycles per tick; value 0 is treated as 1
- enable  in  1  0 pauses the prescaler and blocks new move loads
- flush  in  1  abort current move and empty the queue
- push_valid  in  1  descriptor write request
- push_ready  out  1  queue not full
- push_duration  in  MOVE_W  move length in ticks
- push_increment  in  MOVE_W  signed initial increment
- push_incinc  in  MOVE_W  signed increment-increment
- push_dir  in  1  direction
- load  out  1  one-cycle pulse: act_* outputs are newly valid
- act_increment  out  MOVE_W  active move increment
- act_incinc  out  MOVE_W  active move increment-increment
- act_dir  out  1  active move direction
- tick  out  1  one-cycle datapath advance pulse
- first_tick  out  1  qualifies tick: first tick of the move (datapath uses increment rather than adding incinc)
- busy  out  1  state is LOAD or RUN
- queue_count  out  MOVE_BUFFER_BITS+1  occupied entries
- underrun  out  1  sticky: a move completed with an empty queue while enable=1
- moves_done  out  32  count of completed moves, wraps

Behaviour:
- Reset values: all outputs 0; push_ready=1 after reset; state IDLE; queue empty; prescaler=0; remaining=0.
- Push: accepted when push_valid && push_ready. The entry is visible in queue_count the next cycle. push_ready = !full and does not anticipate a same-cycle pop. Push while full: the descriptor is dropped and state is unchanged.
- States IDLE/LOAD/RUN.
  - IDLE:
    - If enable && queue non-empty: pop the head, go to LOAD.
  - LOAD (1 cycle):
    - Assert load; register act_* and remaining=duration; clear prescaler.
    - If duration==0: moves_done+1, no ticks, go to IDLE. Otherwise go to RUN.
  - RUN:
    - When enable=1, prescaler increments each cycle.
    - When prescaler == max(clock_divisor,1)-1: assert tick for 1 cycle, prescaler=0, remaining-1.
    - first_tick=1 only on the first tick after LOAD.
    - On the tick where remaining reaches 0: moves_done+1. If the queue is non-empty and enable=1, pop and go to LOAD next cycle; otherwise set underrun if queue empty and enable=1, then go to IDLE.
    - enable=0 in RUN freezes the prescaler and remaining; tick stays low.
- Latency:
  - IDLE → first tick: 2 + max(div,1)-1 cycles after the pop cycle.
  - Back-to-back moves: the gap between the last tick of move N and the first tick of N+1 is div+1 cycles (one LOAD bubble).
- clock_divisor changes take effect at the next prescaler compare; they never cause a double tick.
- Flush (highest priority, above push/pop/tick):
  - Same cycle: queue emptied; push ignored, push_ready=0 during flush.
  - Next cycle: state IDLE, remaining=0, prescaler=0, tick=0, underrun cleared.
  - moves_done is not incremented for the aborted move. act_* hold their last values.
- Simultaneous push and pop on a non-full queue: queue_count unchanged, order preserved.
- Reset mid-move: returns to reset values on the next CLK edge; no further tick.
- Width rules:
  - remaining is unsigned MOVE_W.
  - Prescaler is DIV_W wide and compares against the registered divisor.
  - queue_count wraps never (bounded by depth).

Decomposition:
- Shared package/include (configuration.v): MOVE_BUFFER_BITS, MOVE_W, DIV_W, state encodings (S_IDLE/S_LOAD/S_RUN), descriptor width constant (3*MOVE_W+1).
- One sub-module: move_fifo, a synchronous FIFO of packed descriptors with full/empty/count and flush.

Test Plan:
- Reset, then push one move (dur=3, inc=5, incinc=1, dir=1) with div=4 → load 1 cycle after pop; ticks at 4-cycle spacing, 3 total; first_tick only on the first; moves_done=1; underrun=1.
- Push 4 moves with dur=2, div=1 → push_ready=0 at queue_count=4; 5th push dropped; ticks are continuous except a single LOAD bubble between moves; moves_done=4.
- RUN with dur=10, div=2; deassert enable after tick 3 for 7 cycles → no ticks and remaining held; 7 ticks follow after resume.
- Flush asserted mid-move with 2 queued and push_valid=1 → next cycle busy=0, queue_count=0, tick=0; moves_done unchanged.
- Push dur=0 → load pulses once, no tick, moves_done+1, back to IDLE.
- clock_divisor=0 with dur=5 → tick every cycle, exactly 5 ticks.
